// File: rtl/scpu_decode.sv
// Control/execute stage for the small CPU: sequences the fetch unit's PC/IR/DR/RAM
// strobes, owns the 4x8 register file, the ALU and the Z/C flags.
module scpu_decode #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fetch_ir,
    input  logic [DW-1:0] fetch_dr,
    input  logic [DW-1:0] fetch_mem_dout,
    output logic          dc_load_pc,
    output logic          dc_imm,
    output logic [1:0]    dc_addr_sel,
    output logic [DW-1:0] dc_rs,
    output logic [DW-1:0] dc_rd,
    output logic          dc_mem_wr,
    output logic          dc_load_dr,
    output logic          dc_load_ir,
    output logic          halt,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_reg
);

    typedef enum logic [1:0] {
        S_EXEC = 2'd0,
        S_OPND = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LDA = 4'hA;
    localparam logic [3:0] OP_STA = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state_q, state_d;
    logic   z_q, c_q;

    logic [3:0] opcode;
    logic [1:0] ra, rb;
    logic       two_byte;

    logic [3:0][DW-1:0] rf_flat;
    logic               rf_we;
    logic [DW-1:0]      rf_wdata;
    logic               flag_we;

    logic [DW:0]   alu_sum;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    logic       load_pc, imm_sel, mem_wr, load_dr, load_ir;
    logic [1:0] addr_sel;

    assign opcode   = fetch_ir[7:4];
    assign ra       = fetch_ir[3:2];
    assign rb       = fetch_ir[1:0];
    assign two_byte = (opcode == OP_LDI) || ((opcode >= OP_LDA) && (opcode <= OP_JC));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf
            logic [DW-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (rf_we && (ra == 2'(gi))) begin
                    r_q <= rf_wdata;
                end
            end
            assign rf_flat[gi] = r_q;
        end
    endgenerate

    assign dc_rd   = rf_flat[ra];
    assign dc_rs   = rf_flat[rb];
    assign dbg_reg = rf_flat[dbg_sel];

    always_comb begin
        alu_sum = {1'b0, dc_rd} + {1'b0, dc_rs};
        alu_res = '0;
        alu_c   = 1'b0;
        case (opcode)
            OP_ADD: {alu_c, alu_res} = alu_sum;
            OP_SUB: begin
                alu_res = dc_rd - dc_rs;
                alu_c   = (dc_rd < dc_rs);
            end
            OP_AND: alu_res = dc_rd & dc_rs;
            OP_OR:  alu_res = dc_rd | dc_rs;
            OP_XOR: alu_res = dc_rd ^ dc_rs;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_pc  = 1'b0;
        imm_sel  = 1'b0;
        addr_sel = 2'b00;
        mem_wr   = 1'b0;
        load_dr  = 1'b0;
        load_ir  = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = '0;
        flag_we  = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (two_byte) begin
                    // Latch the immediate and step PC past it; IR holds the opcode.
                    load_dr = 1'b1;
                    load_pc = 1'b1;
                    state_d = S_OPND;
                end else if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            rf_we    = 1'b1;
                            rf_wdata = alu_res;
                            flag_we  = 1'b1;
                        end
                        OP_MOV: begin
                            rf_we    = 1'b1;
                            rf_wdata = dc_rs;
                        end
                        OP_LD: begin
                            addr_sel = 2'b01;
                            rf_we    = 1'b1;
                            rf_wdata = fetch_mem_dout;
                        end
                        OP_ST: begin
                            addr_sel = 2'b01;
                            mem_wr   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_OPND: begin
                load_ir = 1'b1;
                load_pc = 1'b1;
                state_d = S_EXEC;
                case (opcode)
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = fetch_dr;
                    end
                    OP_LDA: begin
                        addr_sel = 2'b10;
                        rf_we    = 1'b1;
                        rf_wdata = fetch_mem_dout;
                    end
                    OP_STA: begin
                        addr_sel = 2'b10;
                        mem_wr   = 1'b1;
                    end
                    OP_JMP:  imm_sel = 1'b1;
                    OP_JZ:   imm_sel = z_q;
                    OP_JC:   imm_sel = c_q;
                    default: ;
                endcase
            end
            S_HALT:  ;
            default: state_d = S_EXEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EXEC;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flag_we) begin
                z_q <= (alu_res == '0);
                c_q <= alu_c;
            end
        end
    end

    // Strobes are masked by reset itself so nothing reaches the fetch unit mid-reset.
    assign dc_load_pc  = load_pc & rst_n;
    assign dc_imm      = imm_sel & rst_n;
    assign dc_mem_wr   = mem_wr  & rst_n;
    assign dc_load_dr  = load_dr & rst_n;
    assign dc_load_ir  = load_ir & rst_n;
    assign dc_addr_sel = rst_n ? addr_sel : 2'b00;
    assign halt        = (state_q == S_HALT);

endmodule

// File: tb/tb_scpu_decode.sv
// Bench for scpu_decode: a fetch-unit model drives the DUT, and an instruction-level
// interpreter predicts every cycle's strobes and register contents.
module tb_scpu_decode;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fetch_ir, fetch_dr, fetch_mem_dout;
    logic       dc_load_pc, dc_imm, dc_mem_wr, dc_load_dr, dc_load_ir, halt;
    logic [1:0] dc_addr_sel;
    logic [7:0] dc_rs, dc_rd, dbg_reg;
    logic [1:0] dbg_sel = 2'b00;

    always #5 clk = ~clk;

    scpu_decode #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_ir(fetch_ir), .fetch_dr(fetch_dr), .fetch_mem_dout(fetch_mem_dout),
        .dc_load_pc(dc_load_pc), .dc_imm(dc_imm), .dc_addr_sel(dc_addr_sel),
        .dc_rs(dc_rs), .dc_rd(dc_rd), .dc_mem_wr(dc_mem_wr),
        .dc_load_dr(dc_load_dr), .dc_load_ir(dc_load_ir), .halt(halt),
        .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
    );

    // Fetch unit model
    logic [7:0] env_mem [256];
    logic [7:0] prog_mem [256];
    logic [7:0] env_pc, env_ir, env_dr;
    logic       do_load = 1'b0;

    assign fetch_ir = env_ir;
    assign fetch_dr = env_dr;
    assign fetch_mem_dout = (dc_addr_sel == 2'b01) ? env_mem[dc_rs] :
                            (dc_addr_sel == 2'b10) ? env_mem[env_dr] : env_mem[env_pc];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_ir <= 8'h70;
            env_pc <= 8'h00;
            env_dr <= 8'h00;
            if (do_load) for (int i = 0; i < 256; i++) env_mem[i] <= prog_mem[i];
        end else begin
            if (dc_load_dr) env_dr <= env_mem[env_pc];
            if (dc_load_ir) env_ir <= env_mem[dc_imm ? env_dr : env_pc];
            if (dc_load_pc) env_pc <= (dc_imm ? env_dr : env_pc) + 8'd1;
            if (dc_mem_wr)
                env_mem[(dc_addr_sel == 2'b01) ? dc_rs : (dc_addr_sel == 2'b10) ? env_dr : env_pc] <= dc_rd;
        end
    end

    // Instruction-level reference model
    typedef struct packed {
        logic            load_pc, imm, mem_wr, load_dr, load_ir, halt, lda;
        logic [1:0]      addr_sel;
        logic [7:0]      rd, rs, ir;
        logic [3:0][7:0] rf;
    } rec_t;

    rec_t            q[$];
    logic [7:0]      m_mem [256];
    logic [3:0][7:0] m_rf;
    logic [7:0]      m_pc, m_ir;
    logic            m_z, m_c, m_halted;
    int              cnt_ir, cnt_dr, cnt_wr, cnt_wr10, cnt_imm;
    int              n_tests = 0;
    int              n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = env_mem[i];
        m_rf = '0; m_pc = 8'h00; m_ir = 8'h70;
        m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0;
        q.delete();
        cnt_ir = 0; cnt_dr = 0; cnt_wr = 0; cnt_wr10 = 0; cnt_imm = 0;
    endtask

    task automatic gen_instr();
        rec_t       r, r2;
        logic [3:0] op;
        logic [1:0] ra, rb;
        logic [7:0] imm, fa, nir, a, b, res;
        logic [8:0] s;
        logic       taken;
        op = m_ir[7:4]; ra = m_ir[3:2]; rb = m_ir[1:0];
        r = '0;
        r.rd = m_rf[ra]; r.rs = m_rf[rb]; r.ir = m_ir; r.rf = m_rf;
        if (m_halted) begin
            r.halt = 1'b1;
            q.push_back(r);
        end else if (op == 4'hF) begin
            q.push_back(r);
            m_halted = 1'b1;
        end else if (op == 4'h6 || (op >= 4'hA && op <= 4'hE)) begin
            r2 = r;
            r.load_dr = 1'b1; r.load_pc = 1'b1;
            q.push_back(r);
            imm = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            taken = (op == 4'hC) || (op == 4'hD && m_z) || (op == 4'hE && m_c);
            r2.load_ir = 1'b1; r2.load_pc = 1'b1; r2.imm = taken;
            if (op == 4'hA || op == 4'hB) r2.addr_sel = 2'b10;
            r2.mem_wr = (op == 4'hB);
            r2.lda = (op == 4'hA);
            fa = taken ? imm : m_pc;
            nir = m_mem[fa];
            m_pc = fa + 8'd1;
            if (op == 4'h6) m_rf[ra] = imm;
            if (op == 4'hA) m_rf[ra] = m_mem[imm];
            if (op == 4'hB) m_mem[imm] = m_rf[ra];
            m_ir = nir;
            q.push_back(r2);
        end else begin
            r.load_ir = 1'b1; r.load_pc = 1'b1;
            a = m_rf[ra]; b = m_rf[rb];
            if (op == 4'h8 || op == 4'h9) r.addr_sel = 2'b01;
            r.mem_wr = (op == 4'h9);
            nir = m_mem[m_pc];      // prefetch sees memory before any ST lands
            m_pc = m_pc + 8'd1;
            if (op <= 4'h4) begin
                s = {1'b0, a} + {1'b0, b};
                case (op)
                    4'h0: begin res = s[7:0]; m_c = s[8]; end
                    4'h1: begin res = a - b; m_c = (a < b); end
                    4'h2: begin res = a & b; m_c = 1'b0; end
                    4'h3: begin res = a | b; m_c = 1'b0; end
                    default: begin res = a ^ b; m_c = 1'b0; end
                endcase
                m_z = (res == 8'h00);
                m_rf[ra] = res;
            end
            if (op == 4'h5) m_rf[ra] = b;
            if (op == 4'h8) m_rf[ra] = m_mem[b];
            if (op == 4'h9) m_mem[b] = a;
            m_ir = nir;
            q.push_back(r);
        end
    endtask

    // Compare every cycle until the DUT halts (plus `extra` cycles), or stop at LDA's OPND.
    task automatic run(input int max_cyc, input int extra, input bit stop_lda);
        rec_t r;
        int   n = 0;
        int   post = -1;
        while (1) begin
            @(negedge clk);
            if (q.size() == 0) gen_instr();
            r = q.pop_front();
            chk("load_pc", dc_load_pc, r.load_pc);
            chk("imm", dc_imm, r.imm);
            chk("addr_sel", dc_addr_sel, r.addr_sel);
            chk("mem_wr", dc_mem_wr, r.mem_wr);
            chk("load_dr", dc_load_dr, r.load_dr);
            chk("load_ir", dc_load_ir, r.load_ir);
            chk("halt", halt, r.halt);
            chk("dc_rd", dc_rd, r.rd);
            chk("dc_rs", dc_rs, r.rs);
            chk("fetch_ir", env_ir, r.ir);
            chk("dbg_reg", dbg_reg, r.rf[dbg_sel]);
            cnt_ir   += int'(dc_load_ir);
            cnt_dr   += int'(dc_load_dr);
            cnt_wr   += int'(dc_mem_wr);
            cnt_imm  += int'(dc_imm);
            cnt_wr10 += int'(dc_mem_wr && dc_addr_sel == 2'b10);
            dbg_sel = dbg_sel + 2'd1;
            if (stop_lda && r.lda) return;
            if (r.halt && post < 0) post = 0;
            if (post >= 0) begin
                if (post == extra) return;
                post++;
            end
            n++;
            if (n >= max_cyc) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: got %0d cycles required completion", n);
                return;
            end
        end
    endtask

    task automatic do_reset(input bit load);
        do_load = load;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_load = 1'b0;
        model_reset();
    endtask

    task automatic put_prog(input int n, input logic [63:0] bytes);
        for (int i = 0; i < 256; i++) prog_mem[i] = 8'h00;
        for (int i = 0; i < n; i++) prog_mem[i] = bytes[8*(n-1-i) +: 8];
    endtask

    task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        chk(name, dbg_reg, exp);
    endtask

    initial begin
        // 1: LDI R1,05 ; LDI R2,FB ; ADD R1,R2 ; HLT
        put_prog(6, 64'h0000_6405_68FB_06F0);
        do_load = 1'b1;
        #1;
        chk("reset_halt", halt, 1'b0);
        chk("reset_load_ir", dc_load_ir, 1'b0);
        chk("reset_addr_sel", dc_addr_sel, 2'b00);
        do_reset(1'b1);
        run(60, 2, 1'b0);
        chk_reg("p1_R1", 2'd1, 8'h00);
        chk_reg("p1_R2", 2'd2, 8'hFB);
        chk("p1_pc", env_pc, 8'h06);
        chk("p1_model_z", m_z, 1'b1);
        chk("p1_model_c", m_c, 1'b1);

        // 2: LDI R0,A5 ; STA R0,[80] ; LDA R3,[80] ; HLT
        put_prog(7, 64'h0060_A5B0_80AC_80F0);
        do_reset(1'b1);
        run(60, 2, 1'b0);
        chk("p2_mem80", env_mem[8'h80], 8'hA5);
        chk_reg("p2_R3", 2'd3, 8'hA5);
        chk("p2_wr_cycles", cnt_wr, 1);
        chk("p2_wr_sel10", cnt_wr10, 1);

        // 3: LDI R1,90 ; LDI R2,3C ; ST R2,[R1] ; LD R3,[R1] ; HLT
        put_prog(7, 64'h0064_9068_3C99_8DF0);
        do_reset(1'b1);
        run(60, 2, 1'b0);
        chk("p3_mem90", env_mem[8'h90], 8'h3C);
        chk_reg("p3_R3", 2'd3, 8'h3C);
        chk("p3_model_z", m_z, 1'b0);
        chk("p3_model_c", m_c, 1'b0);

        // 4: JZ 40 (not taken) ; SUB R0,R0 ; JZ 40 (taken) ; mem[40] = HLT
        put_prog(5, 64'h0000_00D0_4010_D040);
        prog_mem[8'h05] = 8'hF0;
        prog_mem[8'h40] = 8'hF0;
        do_reset(1'b1);
        run(60, 2, 1'b0);
        chk("p4_pc", env_pc, 8'h41);
        chk("p4_imm_cycles", cnt_imm, 1);
        chk("p4_model_z", m_z, 1'b1);

        // 5: LDI R1,05 ; LDA R3,[80] -- reset lands during the LDA operand cycle
        put_prog(5, 64'h0000_0064_05AC_80F0);
        prog_mem[8'h80] = 8'h77;
        do_reset(1'b1);
        run(60, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_load_pc", dc_load_pc, 1'b0);
        chk("rst_load_ir", dc_load_ir, 1'b0);
        chk("rst_load_dr", dc_load_dr, 1'b0);
        chk("rst_mem_wr", dc_mem_wr, 1'b0);
        chk("rst_imm", dc_imm, 1'b0);
        chk("rst_addr_sel", dc_addr_sel, 2'b00);
        chk("rst_halt", halt, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);
        do_reset(1'b0);
        run(60, 2, 1'b0);
        chk_reg("p5_R1", 2'd1, 8'h05);
        chk_reg("p5_R3", 2'd3, 8'h77);
        chk("p5_pc", env_pc, 8'h05);

        // 6: five NOPs then HLT
        put_prog(6, 64'h0000_7070_7070_70F0);
        do_reset(1'b1);
        run(60, 2, 1'b0);
        chk("p6_load_ir_cycles", cnt_ir, 6);
        chk("p6_load_dr_cycles", cnt_dr, 0);
        chk("p6_mem_wr_cycles", cnt_wr, 0);
        chk("p6_pc", env_pc, 8'h06);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
